// File: rtl/z80fi_pkg.sv
// Shared Z80FI checker definitions: store-form opcodes, fail-cause codes
// and the LD (nn) checker state encoding.
package z80fi_pkg;

    localparam logic [7:0] OP_LD_NN_A  = 8'h32;
    localparam logic [7:0] OP_LD_NN_HL = 8'h22;
    localparam logic [7:0] OP_PFX_ED   = 8'hED;
    localparam logic [7:0] OP_PFX_DD   = 8'hDD;
    localparam logic [7:0] OP_PFX_FD   = 8'hFD;

    // ED-prefixed LD (nn),dd is 01dd0011: fixed upper pair and low nibble.
    localparam logic [1:0] ED_LD_NN_DD_HI = 2'b01;
    localparam logic [3:0] ED_LD_NN_DD_LO = 4'b0011;

    typedef enum logic [2:0] {
        FAIL_NONE    = 3'd0,
        FAIL_ADDR    = 3'd1,
        FAIL_DATA    = 3'd2,
        FAIL_TIMEOUT = 3'd3,
        FAIL_OVERLAP = 3'd4,
        FAIL_STRAY   = 3'd5
    } fail_code_e;

    typedef enum logic {
        ST_IDLE,
        ST_EXPECT
    } state_e;

    function automatic logic is_index_prefix(input logic [7:0] b);
        return (b == OP_PFX_DD) || (b == OP_PFX_FD);
    endfunction

endpackage

// File: rtl/z80fi_ld_ext_decode.sv
// Combinational decode of the LD (nn),r store family: recognition, byte
// count, target address nn and source value.
module z80fi_ld_ext_decode
    import z80fi_pkg::*;
#(
    parameter int MAX_BYTES = 2
) (
    input  logic        valid_i,
    input  logic [31:0] insn_i,
    input  logic [2:0]  insn_len_i,
    input  logic [15:0] reg1_rdata_i,
    output logic        hit_o,
    output logic [1:0]  byte_count_o,
    output logic [15:0] nn_o,
    output logic [15:0] value_o
);

    localparam logic [1:0] MAX_C = 2'(MAX_BYTES);

    logic [1:0]  count;
    logic [7:0]  op0;
    logic [7:0]  op1;

    assign op0 = insn_i[7:0];
    assign op1 = insn_i[15:8];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value held, which would otherwise infer a latch.
        count   = 2'd0;
        nn_o    = insn_i[31:16];
        value_o = reg1_rdata_i;
        if (valid_i) begin
            if (insn_len_i == 3'd3 && op0 == OP_LD_NN_A) begin
                count   = 2'd1;
                nn_o    = insn_i[23:8];
                value_o = {8'h00, reg1_rdata_i[7:0]};
            end else if (insn_len_i == 3'd3 && op0 == OP_LD_NN_HL) begin
                count = 2'd2;
                nn_o  = insn_i[23:8];
            end else if (insn_len_i == 3'd4 && op0 == OP_PFX_ED &&
                         op1[7:6] == ED_LD_NN_DD_HI && op1[3:0] == ED_LD_NN_DD_LO) begin
                count = 2'd2;
            end else if (insn_len_i == 3'd4 && is_index_prefix(op0) &&
                         op1 == OP_LD_NN_HL) begin
                count = 2'd2;
            end
        end
    end

    // Forms wider than the configured maximum are simply not recognised.
    assign hit_o        = (count != 2'd0) && (count <= MAX_C);
    assign byte_count_o = count;

endmodule

// File: rtl/z80fi_ld_ext_store_checker.sv
// Retirement-driven checker for LD (nn),r stores: follows the bus writes byte
// by byte. Z80FI_STRAY_WR_CHECK_EN flags writes seen while nothing is pending.
module z80fi_ld_ext_store_checker
    import z80fi_pkg::*;
#(
    parameter int MAX_BYTES = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        z80fi_valid,
    input  logic [31:0] z80fi_insn,
    input  logic [2:0]  z80fi_insn_len,
    input  logic [15:0] z80fi_reg1_rdata,
    input  logic        bus_wr_valid,
    input  logic [15:0] bus_wr_addr,
    input  logic [7:0]  bus_wr_data,
    output logic        chk_busy,
    output logic        chk_pass,
    output logic        chk_fail,
    output logic [2:0]  chk_fail_code
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic        dec_hit;
    logic [1:0]  dec_count;
    logic [15:0] dec_nn;
    logic [15:0] dec_value;

    z80fi_ld_ext_decode #(
        .MAX_BYTES (MAX_BYTES)
    ) u_decode (
        .valid_i      (z80fi_valid),
        .insn_i       (z80fi_insn),
        .insn_len_i   (z80fi_insn_len),
        .reg1_rdata_i (z80fi_reg1_rdata),
        .hit_o        (dec_hit),
        .byte_count_o (dec_count),
        .nn_o         (dec_nn),
        .value_o      (dec_value)
    );

    state_e      state_q;
    logic [15:0] exp_addr_q;
    logic [15:0] value_q;
    logic        byte_idx_q;
    logic [1:0]  remaining_q;
    logic [7:0]  idle_cnt_q;
    logic        pass_q;
    logic        fail_q;
    fail_code_e  fail_code_q;

    logic [15:0] exp_addr_d;
    logic [7:0]  idle_cnt_d;
    logic [7:0]  cur_byte;
    logic        addr_ok;
    logic        data_ok;
    logic        wr_last;
    logic        old_done;

    assign exp_addr_d = exp_addr_q + 16'd1;
    assign idle_cnt_d = idle_cnt_q + 8'd1;
    assign cur_byte   = byte_idx_q ? value_q[15:8] : value_q[7:0];
    assign addr_ok    = (bus_wr_addr == exp_addr_q);
    assign data_ok    = (bus_wr_data == cur_byte);
    assign wr_last    = (remaining_q == 2'd1);
    // The outstanding store ends this cycle by its own write (pass or fail),
    // so a same-cycle retirement starts cleanly rather than overlapping.
    assign old_done   = bus_wr_valid && (!addr_ok || !data_ok || wr_last);

    // NOTE: all state here is sequential and uses non-blocking assignments;
    // later assignments in the block deliberately override earlier ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            exp_addr_q  <= 16'h0000;
            value_q     <= 16'h0000;
            byte_idx_q  <= 1'b0;
            remaining_q <= 2'd0;
            idle_cnt_q  <= 8'd0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= FAIL_NONE;
        end else begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
`ifdef Z80FI_STRAY_WR_CHECK_EN
                    if (bus_wr_valid) begin
                        fail_q      <= 1'b1;
                        fail_code_q <= FAIL_STRAY;
                    end
`endif
                end
                ST_EXPECT: begin
                    if (bus_wr_valid) begin
                        if (!addr_ok) begin
                            fail_q      <= 1'b1;
                            fail_code_q <= FAIL_ADDR;
                            state_q     <= ST_IDLE;
                        end else if (!data_ok) begin
                            fail_q      <= 1'b1;
                            fail_code_q <= FAIL_DATA;
                            state_q     <= ST_IDLE;
                        end else begin
                            exp_addr_q  <= exp_addr_d;
                            byte_idx_q  <= byte_idx_q + 1'b1;
                            remaining_q <= remaining_q - 2'd1;
                            idle_cnt_q  <= 8'd0;
                            if (wr_last) begin
                                pass_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end
                    end else if (!dec_hit) begin
                        idle_cnt_q <= idle_cnt_d;
                        if (idle_cnt_d == TIMEOUT_C) begin
                            fail_q      <= 1'b1;
                            fail_code_q <= FAIL_TIMEOUT;
                            state_q     <= ST_IDLE;
                        end
                    end
                    if (dec_hit && !old_done) begin
                        fail_q      <= 1'b1;
                        fail_code_q <= FAIL_OVERLAP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (dec_hit) begin
                state_q     <= ST_EXPECT;
                exp_addr_q  <= dec_nn;
                value_q     <= dec_value;
                byte_idx_q  <= 1'b0;
                remaining_q <= dec_count;
                idle_cnt_q  <= 8'd0;
            end
        end
    end

    assign chk_busy      = (state_q == ST_EXPECT);
    assign chk_pass      = pass_q;
    assign chk_fail      = fail_q;
    assign chk_fail_code = fail_code_q;

endmodule

// File: tb/tb_z80fi_ld_ext_store_checker.sv
// Bench for z80fi_ld_ext_store_checker: directed cases with literal
// expectations plus a randomized run against a queue-based expected-write model.
module tb_z80fi_ld_ext_store_checker;

    localparam int MAXB = 2;
    localparam int TO   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        z80fi_valid = 1'b0;
    logic [31:0] z80fi_insn = '0;
    logic [2:0]  z80fi_insn_len = '0;
    logic [15:0] z80fi_reg1_rdata = '0;
    logic        bus_wr_valid = 1'b0;
    logic [15:0] bus_wr_addr = '0;
    logic [7:0]  bus_wr_data = '0;
    logic        chk_busy;
    logic        chk_pass;
    logic        chk_fail;
    logic [2:0]  chk_fail_code;

    always #5 clk = ~clk;

    z80fi_ld_ext_store_checker #(
        .MAX_BYTES (MAXB),
        .TIMEOUT   (TO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .z80fi_valid      (z80fi_valid),
        .z80fi_insn       (z80fi_insn),
        .z80fi_insn_len   (z80fi_insn_len),
        .z80fi_reg1_rdata (z80fi_reg1_rdata),
        .bus_wr_valid     (bus_wr_valid),
        .bus_wr_addr      (bus_wr_addr),
        .bus_wr_data      (bus_wr_data),
        .chk_busy         (chk_busy),
        .chk_pass         (chk_pass),
        .chk_fail         (chk_fail),
        .chk_fail_code    (chk_fail_code)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    // Model: the list of bus writes still owed by the outstanding store.
    wr_t        mq[$];
    int         m_idle = 0;
    logic       e_busy = 1'b0;
    logic       e_pass = 1'b0;
    logic       e_fail = 1'b0;
    logic [2:0] e_code = 3'd0;
    bit         cmp_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void ref_decode(input logic v, input logic [31:0] insn, input logic [2:0] len,
                                       input logic [15:0] r, output int n, output logic [15:0] nn,
                                       output logic [15:0] val);
        n   = 0;
        nn  = insn[31:16];
        val = r;
        if (v) begin
            if (len == 3'd3 && insn[7:0] == 8'h32) begin
                n = 1; nn = insn[23:8]; val = {8'h00, r[7:0]};
            end else if (len == 3'd3 && insn[7:0] == 8'h22) begin
                n = 2; nn = insn[23:8];
            end else if (len == 3'd4 && insn[7:0] == 8'hED &&
                         insn[15:8] inside {8'h43, 8'h53, 8'h63, 8'h73}) begin
                n = 2;
            end else if (len == 3'd4 && insn[7:0] inside {8'hDD, 8'hFD} && insn[15:8] == 8'h22) begin
                n = 2;
            end
        end
        if (n > MAXB) n = 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_idle = 0;
        e_busy = 1'b0;
        e_pass = 1'b0;
        e_fail = 1'b0;
        e_code = 3'd0;
    endtask

    task automatic set_fail(input int c);
        e_fail = 1'b1;
        e_code = 3'(c);
    endtask

    // Advances the model by the cycle whose inputs are currently driven.
    task automatic model_step();
        int          n;
        logic [15:0] nn;
        logic [15:0] val;
        bit          had;
        had = (mq.size() > 0);
        ref_decode(z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_reg1_rdata, n, nn, val);
        e_pass = 1'b0;
        e_fail = 1'b0;
        if (had) begin
            if (bus_wr_valid) begin
                if (bus_wr_addr != mq[0].addr) begin
                    set_fail(1); mq.delete();
                end else if (bus_wr_data != mq[0].data) begin
                    set_fail(2); mq.delete();
                end else begin
                    void'(mq.pop_front());
                    m_idle = 0;
                    if (mq.size() == 0) e_pass = 1'b1;
                end
            end else if (n == 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    set_fail(3); mq.delete();
                end
            end
            if (n != 0 && mq.size() > 0) set_fail(4);
        end else begin
`ifdef Z80FI_STRAY_WR_CHECK_EN
            if (bus_wr_valid) set_fail(5);
`endif
        end
        if (n != 0) begin
            mq.delete();
            for (int i = 0; i < n; i++) begin
                wr_t w;
                w.addr = nn + 16'(i);
                w.data = 8'(val >> (8 * i));
                mq.push_back(w);
            end
            m_idle = 0;
        end
        e_busy = (mq.size() > 0);
    endtask

    // Compare process: DUT outputs against the model after every edge.
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("busy", 32'(chk_busy), 32'(e_busy));
            check("pass", 32'(chk_pass), 32'(e_pass));
            check("fail", 32'(chk_fail), 32'(e_fail));
            check("fail_code", 32'(chk_fail_code), 32'(e_code));
        end
    end

    task automatic cycle(input logic v, input logic [31:0] insn, input logic [2:0] len,
                         input logic [15:0] r, input logic wr, input logic [15:0] a,
                         input logic [7:0] d);
        @(negedge clk);
        z80fi_valid      = v;
        z80fi_insn       = insn;
        z80fi_insn_len   = len;
        z80fi_reg1_rdata = r;
        bus_wr_valid     = wr;
        bus_wr_addr      = a;
        bus_wr_data      = d;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 3'd0, 16'h0, 1'b0, 16'h0, 8'h0);
    endtask

    task automatic write(input logic [15:0] a, input logic [7:0] d);
        cycle(1'b0, 32'h0, 3'd0, 16'h0, 1'b1, a, d);
    endtask

    task automatic retire(input logic [31:0] insn, input logic [2:0] len, input logic [15:0] r);
        cycle(1'b1, insn, len, r, 1'b0, 16'h0, 8'h0);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #2;
        check("reset_busy", 32'(chk_busy), 32'd0);
        check("reset_code", 32'(chk_fail_code), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();

        // LD (nn),DE: ED 53 34 12, DE=BEEF.
        retire(32'h1234_53ED, 3'd4, 16'hBEEF);
        check("ed53_busy", 32'(chk_busy), 32'd1);
        write(16'h1234, 8'hEF);
        check("ed53_mid_pass", 32'(chk_pass), 32'd0);
        write(16'h1235, 8'hBE);
        check("ed53_pass", 32'(chk_pass), 32'd1);
        check("ed53_busy_end", 32'(chk_busy), 32'd0);
        idle();
        check("ed53_pass_once", 32'(chk_pass), 32'd0);

        // LD (FFFF),HL with address wrap.
        retire(32'h00FF_FF22, 3'd3, 16'hA55A);
        write(16'hFFFF, 8'h5A);
        write(16'h0000, 8'hA5);
        check("wrap_pass", 32'(chk_pass), 32'd1);

        // LD (8000),IX with a corrupt second byte.
        retire(32'h8000_22DD, 3'd4, 16'h1357);
        write(16'h8000, 8'h57);
        write(16'h8001, 8'h14);
        check("data_fail", 32'(chk_fail), 32'd1);
        check("data_code", 32'(chk_fail_code), 32'd2);
        check("data_busy", 32'(chk_busy), 32'd0);
        idle();

        // LD (4000),A then silence: timeout on the 4th idle edge.
        retire(32'h0040_0032, 3'd3, 16'h0077);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("to_early", 32'(chk_fail), 32'd0);
        end
        idle();
        check("to_fail", 32'(chk_fail), 32'd1);
        check("to_code", 32'(chk_fail_code), 32'd3);
        idle();

        // Overlap: LD (2000),HL abandoned by LD (3000),A.
        retire(32'h0020_0022, 3'd3, 16'h1111);
        retire(32'h0030_0032, 3'd3, 16'h0099);
        check("ovl_fail", 32'(chk_fail), 32'd1);
        check("ovl_code", 32'(chk_fail_code), 32'd4);
        check("ovl_busy", 32'(chk_busy), 32'd1);
        write(16'h3000, 8'h99);
        check("ovl_new_pass", 32'(chk_pass), 32'd1);

        // Write while idle.
        write(16'h0100, 8'h00);
`ifdef Z80FI_STRAY_WR_CHECK_EN
        check("stray_fail", 32'(chk_fail), 32'd1);
        check("stray_code", 32'(chk_fail_code), 32'd5);
`else
        check("stray_fail", 32'(chk_fail), 32'd0);
        check("stray_code", 32'(chk_fail_code), 32'd4);
`endif

        // Reset in the middle of a transaction.
        retire(32'h1234_53ED, 3'd4, 16'hBEEF);
        write(16'h1234, 8'hEF);
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        check("rst_busy", 32'(chk_busy), 32'd0);
        check("rst_pass", 32'(chk_pass), 32'd0);
        check("rst_fail", 32'(chk_fail), 32'd0);
        check("rst_code", 32'(chk_fail_code), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            logic        v;
            logic [31:0] insn;
            logic [2:0]  len;
            logic [15:0] r;
            logic        wr;
            logic [15:0] a;
            logic [7:0]  d;
            int          sel;
            v    = ($urandom_range(0, 99) < ((mq.size() > 0) ? 6 : 30));
            r    = 16'($urandom);
            insn = $urandom;
            len  = 3'd4;
            sel  = $urandom_range(0, 6);
            case (sel)
                0: begin insn[7:0] = 8'h32; len = 3'd3; end
                1: begin insn[7:0] = 8'h22; len = 3'd3; end
                2: begin insn[7:0] = 8'hED; insn[15:14] = 2'b01; insn[11:8] = 4'b0011; end
                3: begin insn[15:0] = 16'h22DD; end
                4: begin insn[15:0] = 16'h22FD; end
                5: begin len = 3'($urandom); end
                default: begin insn[7:0] = 8'h32; end
            endcase
            wr = 1'b0;
            a  = 16'($urandom);
            d  = 8'($urandom);
            if (mq.size() > 0) begin
                sel = $urandom_range(0, 99);
                if (sel < 62) begin
                    wr = 1'b1; a = mq[0].addr; d = mq[0].data;
                end else if (sel < 67) begin
                    wr = 1'b1; a = mq[0].addr ^ 16'(1 << $urandom_range(0, 15)); d = mq[0].data;
                end else if (sel < 72) begin
                    wr = 1'b1; a = mq[0].addr; d = mq[0].data ^ 8'(1 << $urandom_range(0, 7));
                end
            end else begin
                wr = ($urandom_range(0, 99) < 5);
            end
            cycle(v, insn, len, r, wr, a, d);
        end

        repeat (6) idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
